hall_decoder: RTL
=================

HALL_DECODER -- requirements
Module: hall_decoder

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4, the number of consecutive stable cycles (range 1..15) before a hall code change is accepted.
REQ-002 SHALL have parameter POS_WIDTH, default 16, the width of the signed step position counter.
REQ-003 SHALL have parameter PERIOD_WIDTH, default 24, the width of the step period measurement.
REQ-004 CLK  in  1  single clock; all state on its rising edge.
REQ-005 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-006 HALL_1, HALL_2, HALL_3  in  1 each  raw asynchronous hall sensor inputs.
REQ-007 ERR_CLR  in  1  synchronous clear of HALL_ERR.
REQ-008 SECTOR  out  3  decoded rotor sector 0..5; 7 = invalid or unknown.
REQ-009 DIR  out  1  last valid step direction; 1 = forward, 0 = reverse.
REQ-010 POSITION  out  POS_WIDTH  signed two's-complement step count.
REQ-011 PERIOD  out  PERIOD_WIDTH  CLK cycles between the last two valid steps.
REQ-012 EDGE  out  1  one-cycle pulse on every accepted hall code change.
REQ-013 STALL  out  1  no valid step within the measurement range.
REQ-014 HALL_ERR  out  1  sticky error: sector skip or illegal code.

Function
REQ-015 SHALL pass each HALL_x through a 2-flop synchronizer, forming code C = {HALL_3, HALL_2, HALL_1}.
REQ-016 SHALL accept C as the new filtered code only when C differs from the filtered code and has been unchanged for FILTER_LEN consecutive cycles; any change of C restarts the stability count.
REQ-017 SHALL update SECTOR, DIR, POSITION, PERIOD, STALL and EDGE on the edge the code is accepted, exactly FILTER_LEN+2 cycles after the first CLK edge that samples the new raw value.
REQ-018 SHALL map codes 001,011,010,110,100,101 to sectors 0,1,2,3,4,5; codes 000 and 111 SHALL be illegal.
REQ-019 On accept, with both old and new sectors valid, SHALL compute d = (new - old) mod 6:
- d=1: forward; DIR=1; POSITION+1.
- d=5: reverse; DIR=0; POSITION-1.
- d=2,3,4: skip; HALL_ERR=1; POSITION and DIR unchanged.
REQ-020 An accept from an invalid or unknown old sector (resync) SHALL set SECTOR only, without a step, error or PERIOD update.
REQ-021 An accept of an illegal code SHALL set SECTOR=7 and HALL_ERR=1, with POSITION and DIR unchanged.
REQ-022 POSITION SHALL wrap modulo 2^POS_WIDTH with no saturation.
REQ-023 SHALL keep a period counter that loads 1 on a valid step (d=1 or 5), otherwise increments each cycle, saturating at all-ones.
REQ-024 On a valid step with STALL=0, PERIOD SHALL load the counter value, so steps at cycles t0 and t1 give PERIOD = t1 - t0.
REQ-025 When the counter reaches all-ones, STALL=1 and PERIOD=all-ones.
REQ-026 While STALL=1, a valid step SHALL restart the counter but leave PERIOD unchanged; STALL SHALL clear on the next valid step, which loads a measured PERIOD.
REQ-027 ERR_CLR=1 SHALL clear HALL_ERR on the next edge; an error event in the same cycle SHALL win, leaving HALL_ERR=1.
REQ-028 EDGE SHALL pulse for every accept, including resync, skip and illegal codes.

Reset
REQ-029 RST_N=0 SHALL immediately force:
- synchronizers and filtered code = 000 (unknown); stability count 0;
- SECTOR=7, DIR=0, POSITION=0, EDGE=0, HALL_ERR=0;
- PERIOD = all-ones, STALL=1, period counter = all-ones.
REQ-030 Reset asserted mid-operation SHALL discard any pending filtered change; decoding SHALL resume from the resync state after release.

Verification
REQ-031 Reset, then hall=001 held -> EDGE on cycle 6 after first sample, SECTOR=0, POSITION=0, HALL_ERR=0, STALL=1.
REQ-032 From sector 0, forward sequence 011,010,110,100,101,001, each held 100 cycles -> POSITION=6, DIR=1, STALL=0 after the 2nd step, PERIOD=100.
REQ-033 From sector 0, reverse sequence 101,100,110,010,011,001 -> POSITION=0xFFFA (-6), DIR=0.
REQ-034 At 001, a 3-cycle glitch to 011 -> no EDGE; SECTOR, POSITION and HALL_ERR unchanged.
REQ-035 Error handling:
- 001 -> 010 -> HALL_ERR=1, POSITION unchanged.
- 111 -> SECTOR=7, HALL_ERR=1.
- ERR_CLR coincident with a new error -> HALL_ERR stays 1; ERR_CLR alone -> 0 next cycle.
REQ-036 With PERIOD_WIDTH=8: steps stop for 255 cycles -> STALL=1, PERIOD=0xFF; RST_N pulsed low mid-sequence -> all outputs at REQ-029 values asynchronously.

Source files
------------

// File: rtl/hall_decoder_if.sv
// hall_decoder_if: hall sensor inputs, error clear and decoded outputs of hall_decoder
//   master: drives hall_1..3 and err_clr, observes the decoded outputs
//   slave : the decoder side
interface hall_decoder_if #(
  parameter int POS_WIDTH    = 16,
  parameter int PERIOD_WIDTH = 24
);
  logic                    hall_1, hall_2, hall_3, err_clr;
  logic [2:0]              sector;
  logic                    dir, edge_pulse, stall, hall_err;
  logic [POS_WIDTH-1:0]    position;
  logic [PERIOD_WIDTH-1:0] period;
  modport master (
    output hall_1, hall_2, hall_3, err_clr,
    input  sector, dir, position, period, edge_pulse, stall, hall_err
  );
  modport slave (
    input  hall_1, hall_2, hall_3, err_clr,
    output sector, dir, position, period, edge_pulse, stall, hall_err
  );
endinterface

// File: rtl/hall_decoder.sv
// hall_decoder: synchronizes and filters three hall sensors, decodes sector,
// direction, signed step position, step period, stall and sticky error.
//   clk_i   : clock, all state on rising edge
//   rst_n_i : asynchronous active-low reset
//   bus     : hall_decoder_if.slave (hall_1..3, err_clr in; sector, dir,
//             position, period, edge_pulse, stall, hall_err out)
module hall_decoder #(
  parameter int FILTER_LEN   = 4,
  parameter int POS_WIDTH    = 16,
  parameter int PERIOD_WIDTH = 24
) (
  input logic           clk_i,
  input logic           rst_n_i,
  hall_decoder_if.slave bus
);
  localparam logic [3:0]              FL   = 4'(FILTER_LEN);
  localparam logic [PERIOD_WIDTH-1:0] PMAX = '1;
  logic [2:0]              sync1_q, sync2_q, filt_q, filt_d, sector_q, sector_d, new_sec;
  logic [3:0]              cnt_q, cnt_d, dsum, diff;
  logic                    dir_q, dir_d, edge_q, err_q, err_d, stall_q, stall_d;
  logic                    accept, old_ok, new_ok, fwd, rev, step, err_ev;
  logic [POS_WIDTH-1:0]    pos_q, pos_d;
  logic [PERIOD_WIDTH-1:0] per_q, per_d, pcnt_q, pcnt_d;
  function automatic logic [2:0] decode(input logic [2:0] c);
    case (c)
      3'b001:  return 3'd0;
      3'b011:  return 3'd1;
      3'b010:  return 3'd2;
      3'b110:  return 3'd3;
      3'b100:  return 3'd4;
      3'b101:  return 3'd5;
      default: return 3'd7;
    endcase
  endfunction
  always_comb begin
    // sync1 != sync2 means the synchronized code changes on this edge
    cnt_d    = (sync1_q != sync2_q) ? 4'd0 : (cnt_q == FL) ? cnt_q : cnt_q + 4'd1;
    accept   = (cnt_q == FL) && (sync2_q != filt_q);
    filt_d   = accept ? sync2_q : filt_q;
    new_sec  = decode(sync2_q);
    // (new - old) mod 6, both operands in 0..5
    dsum     = {1'b0, new_sec} + 4'd6 - {1'b0, sector_q};
    diff     = (dsum >= 4'd6) ? dsum - 4'd6 : dsum;
    old_ok   = sector_q != 3'd7;
    new_ok   = new_sec != 3'd7;
    fwd      = accept && old_ok && new_ok && diff == 4'd1;
    rev      = accept && old_ok && new_ok && diff == 4'd5;
    step     = fwd || rev;
    err_ev   = accept && (!new_ok || (old_ok && !step));
    sector_d = accept ? new_sec : sector_q;
    dir_d    = fwd ? 1'b1 : rev ? 1'b0 : dir_q;
    pos_d    = fwd ? pos_q + 1'b1 : rev ? pos_q - 1'b1 : pos_q;
    err_d    = err_ev ? 1'b1 : bus.err_clr ? 1'b0 : err_q;
    pcnt_d   = step ? PERIOD_WIDTH'(1) : (pcnt_q == PMAX) ? pcnt_q : pcnt_q + 1'b1;
    // a saturated counter means the interval is unmeasurable: restart only
    stall_d  = step ? (pcnt_q == PMAX) : (pcnt_d == PMAX) ? 1'b1 : stall_q;
    per_d    = step ? ((pcnt_q == PMAX) ? per_q : pcnt_q) : (pcnt_d == PMAX) ? PMAX : per_q;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      filt_q   <= '0;
      cnt_q    <= '0;
      sector_q <= 3'd7;
      dir_q    <= 1'b0;
      pos_q    <= '0;
      edge_q   <= 1'b0;
      err_q    <= 1'b0;
      per_q    <= PMAX;
      pcnt_q   <= PMAX;
      stall_q  <= 1'b1;
    end else begin
      sync1_q  <= {bus.hall_3, bus.hall_2, bus.hall_1};
      sync2_q  <= sync1_q;
      filt_q   <= filt_d;
      cnt_q    <= cnt_d;
      sector_q <= sector_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
      edge_q   <= accept;
      err_q    <= err_d;
      per_q    <= per_d;
      pcnt_q   <= pcnt_d;
      stall_q  <= stall_d;
    end
  end
  assign bus.sector     = sector_q;
  assign bus.dir        = dir_q;
  assign bus.position   = pos_q;
  assign bus.period     = per_q;
  assign bus.edge_pulse = edge_q;
  assign bus.stall      = stall_q;
  assign bus.hall_err   = err_q;
endmodule
